// File: rtl/sonar_ranger.sv
// sonar_ranger: HC-SR04 style trigger/echo ranging controller.
// Optional echo deglitch filter enabled by SONAR_DEGLITCH_EN.
module sonar_ranger #(
  parameter int unsigned CLKS_PER_US = 50,
  parameter int unsigned TRIG_US     = 10,
  parameter int unsigned TIMEOUT_US  = 30000,
  parameter int unsigned HOLDOFF_US  = 60000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        echo,
  output logic        trig,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic [31:0] echo_us
);

  localparam int unsigned PW = $clog2(CLKS_PER_US);
  localparam logic [PW-1:0] PRE_MAX = PW'(CLKS_PER_US - 1);
  localparam logic [31:0] TRIG_LAST = 32'(TRIG_US - 1);
  localparam logic [31:0] TO_LAST   = 32'(TIMEOUT_US - 1);
  localparam logic [31:0] TO_VAL    = 32'(TIMEOUT_US);
  localparam logic [31:0] HO_LAST   = 32'(HOLDOFF_US - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG,
    S_WAIT,
    S_MEAS,
    S_DONE,
    S_HOLD
  } state_t;

  state_t state_q, state_d;
  logic [PW-1:0] pre_q;
  logic [31:0] cnt_q;
  logic [31:0] echo_us_q;
  logic timeout_q;
  logic s1_q, s2_q;
  logic echo_f;
  logic tick;
  logic pre_clr, cnt_clr, cnt_inc;
  logic res_ld, res_to;
  logic [31:0] res_us;

  // Two-flop synchronizer for the asynchronous echo pin
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= echo;
      s2_q <= s1_q;
    end
  end

`ifdef SONAR_DEGLITCH_EN
  logic [2:0] hist_q;
  logic filt_q;

  // Filtered echo follows only after four equal consecutive samples
  always_comb begin
    echo_f = filt_q;
    if (hist_q == {3{s2_q}}) echo_f = s2_q;
  end

  // Sample history and held filter output
  always_ff @(posedge clk) begin
    if (!reset) begin
      hist_q <= 3'b000;
      filt_q <= 1'b0;
    end else begin
      hist_q <= {hist_q[1:0], s2_q};
      filt_q <= echo_f;
    end
  end
`else
  // Without the filter the synchronized echo drives decisions directly
  always_comb begin
    echo_f = s2_q;
  end
`endif

  assign tick = (pre_q == PRE_MAX);

  // Microsecond prescaler, restarted on each timed state entry
  always_ff @(posedge clk) begin
    if (!reset) begin
      pre_q <= '0;
    end else if (pre_clr || tick) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_q + 1'b1;
    end
  end

  // Microsecond counter shared by all timed states
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (cnt_clr) begin
      cnt_q <= '0;
    end else if (cnt_inc) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  // Next-state and result capture decisions
  always_comb begin
    state_d = state_q;
    pre_clr = 1'b0;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    res_ld  = 1'b0;
    res_to  = 1'b0;
    res_us  = '0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_TRIG;
          pre_clr = 1'b1;
          cnt_clr = 1'b1;
        end
      end
      S_TRIG: begin
        if (tick && cnt_q == TRIG_LAST) begin
          state_d = S_WAIT;
          pre_clr = 1'b1;
          cnt_clr = 1'b1;
        end else if (tick) begin
          cnt_inc = 1'b1;
        end
      end
      S_WAIT: begin
        if (echo_f) begin
          state_d = S_MEAS;
          pre_clr = 1'b1;
          cnt_clr = 1'b1;
        end else if (tick && cnt_q == TO_LAST) begin
          state_d = S_DONE;
          res_ld  = 1'b1;
          res_to  = 1'b1;
        end else if (tick) begin
          cnt_inc = 1'b1;
        end
      end
      S_MEAS: begin
        // The rise cycle belongs to the pulse, so a tick on the
        // falling cycle still counts toward the width.
        if (!echo_f) begin
          state_d = S_DONE;
          res_ld  = 1'b1;
          res_us  = cnt_q + (tick ? 32'd1 : 32'd0);
        end else if (tick && cnt_q == TO_LAST) begin
          state_d = S_DONE;
          res_ld  = 1'b1;
          res_us  = TO_VAL;
          res_to  = 1'b1;
        end else if (tick) begin
          cnt_inc = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_HOLD;
        pre_clr = 1'b1;
        cnt_clr = 1'b1;
      end
      S_HOLD: begin
        if (tick && cnt_q == HO_LAST) begin
          state_d = S_IDLE;
        end else if (tick) begin
          cnt_inc = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and result registers; results show during the done cycle
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      echo_us_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (res_ld) begin
        echo_us_q <= res_us;
        timeout_q <= res_to;
      end
    end
  end

  assign trig    = (state_q == S_TRIG) & reset;
  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign timeout = timeout_q;
  assign echo_us = echo_us_q;

endmodule

// File: tb/tb_sonar_ranger.sv
// tb_sonar_ranger: directed and random ranging runs
// checked against an arithmetic timing model.
module tb_sonar_ranger;

  localparam int CPU  = 50;
  localparam int TRGU = 10;
  localparam int TOU  = 300;
  localparam int HOU  = 20;
  localparam int TO_CYC = TOU * CPU;
`ifdef SONAR_DEGLITCH_EN
  localparam int FD   = 3;
  localparam int MINW = 4;
`else
  localparam int FD   = 0;
  localparam int MINW = 1;
`endif

  logic clk, reset, start, echo;
  logic trig, busy, done, timeout;
  logic [31:0] echo_us;

  int vectors = 0;
  int miscompares = 0;

  sonar_ranger #(
    .CLKS_PER_US(CPU),
    .TRIG_US(TRGU),
    .TIMEOUT_US(TOU),
    .HOLDOFF_US(HOU)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .echo(echo),
    .trig(trig),
    .busy(busy),
    .done(done),
    .timeout(timeout),
    .echo_us(echo_us)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // One full measurement; echo timing is relative to the
  // first cycle trig is seen low. sa/sb inject extra starts.
  task automatic measure(input string nm, input int dly,
                         input int wid, input int sa,
                         input int sb);
    int tl, dk, hold, nd, nr, edk, eus;
    logic [31:0] us;
    logic to, eto, ptrig;
    if (wid < MINW) begin
      edk = TO_CYC; eus = 0; eto = 1'b1;
    end else if (wid > TO_CYC) begin
      edk = dly + 3 + FD + TO_CYC; eus = TOU; eto = 1'b1;
    end else begin
      edk = dly + 3 + FD + wid; eus = wid / CPU; eto = 1'b0;
    end
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    check({nm, ".trig_on"}, {31'd0, trig}, 32'd1);
    check({nm, ".busy_on"}, {31'd0, busy}, 32'd1);
    tl = 0;
    while (trig && tl < 2000) begin
      tl++;
      @(negedge clk);
    end
    check({nm, ".trig_len"}, tl, TRGU * CPU);
    dk = -1; hold = 0; nd = 0; nr = 0;
    us = '0; to = 1'b0; ptrig = 1'b0;
    for (int k = 0; k < 40000; k++) begin
      if (done) begin
        nd++;
        if (dk < 0) begin
          dk = k; us = echo_us; to = timeout;
        end
      end
      if (dk >= 0 && k > dk) begin
        if (!busy) break;
        hold++;
      end
      if (trig && !ptrig) nr++;
      ptrig = trig;
      echo  = (k >= dly && k < dly + wid);
      start = (k == sa || k == sb);
      @(negedge clk);
    end
    start = 1'b0;
    echo  = 1'b0;
    repeat (20) begin
      if (trig) nr++;
      @(negedge clk);
    end
    check({nm, ".done_at"}, dk, edk);
    check({nm, ".echo_us"}, us, eus);
    check({nm, ".timeout"}, {31'd0, to}, {31'd0, eto});
    check({nm, ".holdoff"}, hold, HOU * CPU);
    check({nm, ".n_done"}, nd, 1);
    check({nm, ".n_retrig"}, nr, 0);
  endtask

  initial begin
    int tl, nd, d, w;
    reset = 1'b0; start = 1'b0; echo = 1'b0;
    repeat (3) @(negedge clk);
    check("rst.trig", {31'd0, trig}, 32'd0);
    check("rst.busy", {31'd0, busy}, 32'd0);
    check("rst.done", {31'd0, done}, 32'd0);
    check("rst.timeout", {31'd0, timeout}, 32'd0);
    check("rst.echo_us", echo_us, 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    measure("normal", 5000, 5000, -1, -1);
    measure("noecho", 0, 0, -1, -1);
    measure("overrange", 0, 20000, -1, -1);
    measure("busystart", 100, 1000, 600, 1500);

    // Reset during TRIG drops trig in the same cycle
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (100) @(negedge clk);
    check("rtrig.pre", {31'd0, trig}, 32'd1);
    reset = 1'b0;
    #1;
    check("rtrig.same", {31'd0, trig}, 32'd0);
    @(negedge clk) reset = 1'b1;
    check("rtrig.busy", {31'd0, busy}, 32'd0);

    // Reset mid-measurement clears everything, no done
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    tl = 0;
    while (trig && tl < 2000) begin
      tl++;
      @(negedge clk);
    end
    echo = 1'b1;
    repeat (300) @(negedge clk);
    check("rmeas.busy_pre", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    @(negedge clk) reset = 1'b1;
    check("rmeas.trig", {31'd0, trig}, 32'd0);
    check("rmeas.busy", {31'd0, busy}, 32'd0);
    check("rmeas.done", {31'd0, done}, 32'd0);
    check("rmeas.timeout", {31'd0, timeout}, 32'd0);
    check("rmeas.echo_us", echo_us, 32'd0);
    echo = 1'b0;
    nd = 0;
    repeat (30) begin
      if (done || busy) nd++;
      @(negedge clk);
    end
    check("rmeas.quiet", nd, 0);
    measure("after_rst", 50, 777, -1, -1);

    measure("glitch", 200, 2, -1, -1);

    for (int i = 0; i < 3; i++) begin
      d = $urandom_range(1000, 0);
      w = $urandom_range(2000, 1);
      measure($sformatf("rand%0d", i), d, w, -1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
